// File: rtl/alu_pkg.sv
// Shared constants for the execute-stage ALU: operation codes and default width.
// Extended codes are only decoded when ALU_EXT_OPS_EN is defined.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1100;

endpackage

// File: rtl/alu_addsub.sv
// Shared WIDTH-bit adder/subtractor: sum, carry-out and two's-complement overflow.
// Subtraction is a + ~b + 1, so carry-out=1 means a >= b as unsigned values.
module alu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    sub,
  output logic        [WIDTH-1:0] sum,
  output logic                    cout,
  output logic                    ovf
);

  logic [WIDTH-1:0] b_eff;

  assign b_eff       = sub ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  // Overflow when the effective addends agree in sign but the sum does not.
  assign ovf         = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_unit.sv
// Registered integer ALU for the execute stage: one cycle latency, full throughput.
// Define ALU_EXT_OPS_EN to add XOR, SLL, SRL, SRA and SLTU; otherwise those codes are illegal.
module alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       operation,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             overflow,
  output logic             illegal,
  output logic             out_valid
);

  logic signed [WIDTH-1:0] in1_s;
  logic signed [WIDTH-1:0] in2_s;
  logic        [WIDTH-1:0] sum_p0;
  logic                    cout_p0;
  logic                    ovf_as_p0;
  logic                    sub_p0;
  logic                    slt_p0;
  logic        [WIDTH-1:0] res_p0;
  logic                    ovf_p0;
  logic                    ill_p0;
  logic                    zero_p0;

  logic        [WIDTH-1:0] res_p1;
  logic                    zero_p1;
  logic                    ovf_p1;
  logic                    ill_p1;
  logic                    vld_p1;

  assign in1_s = $signed(in1);
  assign in2_s = $signed(in2);

`ifdef ALU_EXT_OPS_EN
  localparam int SHW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  logic [SHW-1:0] shamt_p0;
  assign shamt_p0 = in2[SHW-1:0];
  assign sub_p0   = (operation == OP_SUB) || (operation == OP_SLT) || (operation == OP_SLTU);
`else
  logic unused_cout;
  assign unused_cout = cout_p0;
  assign sub_p0      = (operation == OP_SUB) || (operation == OP_SLT);
`endif

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (in1_s),
    .b    (in2_s),
    .sub  (sub_p0),
    .sum  (sum_p0),
    .cout (cout_p0),
    .ovf  (ovf_as_p0)
  );

  // Sign of the difference corrected by overflow keeps SLT right at the extremes.
  assign slt_p0 = sum_p0[WIDTH-1] ^ ovf_as_p0;

  always_comb begin
    res_p0 = '0;
    ovf_p0 = 1'b0;
    ill_p0 = 1'b0;
    case (operation)
      OP_AND: res_p0 = in1 & in2;
      OP_OR:  res_p0 = in1 | in2;
      OP_ADD: begin
        res_p0 = sum_p0;
        ovf_p0 = ovf_as_p0;
      end
      OP_SUB: begin
        res_p0 = sum_p0;
        ovf_p0 = ovf_as_p0;
      end
      OP_SLT: res_p0 = {{(WIDTH-1){1'b0}}, slt_p0};
      OP_NOR: res_p0 = ~(in1 | in2);
`ifdef ALU_EXT_OPS_EN
      OP_XOR:  res_p0 = in1 ^ in2;
      OP_SLL:  res_p0 = in1 << shamt_p0;
      OP_SRL:  res_p0 = in1 >> shamt_p0;
      OP_SRA:  res_p0 = in1_s >>> shamt_p0;
      OP_SLTU: res_p0 = {{(WIDTH-1){1'b0}}, ~cout_p0};
`endif
      default: ill_p0 = 1'b1;
    endcase
  end

  assign zero_p0 = (res_p0 == '0);

  // ---- p0 -> p1: output registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      res_p1  <= '0;
      zero_p1 <= 1'b1;
      ovf_p1  <= 1'b0;
      ill_p1  <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        res_p1  <= res_p0;
        zero_p1 <= zero_p0;
        ovf_p1  <= ovf_p0;
        ill_p1  <= ill_p0;
      end
    end
  end

  assign out       = res_p1;
  assign zero      = zero_p1;
  assign overflow  = ovf_p1;
  assign illegal   = ill_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: a reference model pushes expected results to a
// queue as each operation is driven; the queue is popped when the registered result appears.
module tb_alu_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic [3:0]   operation;
  logic [W-1:0] out;
  logic         zero;
  logic         overflow;
  logic         illegal;
  logic         out_valid;

  typedef struct packed {
    logic [W-1:0] res;
    logic         zf;
    logic         of;
    logic         il;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  alu_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in1       (in1),
    .in2       (in2),
    .operation (operation),
    .out       (out),
    .zero      (zero),
    .overflow  (overflow),
    .illegal   (illegal),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa;
    longint sb;
    longint r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e  = '0;
    case (op)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0010: begin
        r = sa + sb;
        e.res = a + b;
        e.of = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      4'b0110: begin
        r = sa - sb;
        e.res = a - b;
        e.of = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      4'b0111: e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'b1100: e.res = ~(a | b);
`ifdef ALU_EXT_OPS_EN
      4'b0011: e.res = a ^ b;
      4'b0100: e.res = a << b[4:0];
      4'b0101: e.res = a >> b[4:0];
      4'b1000: e.res = $signed(a) >>> b[4:0];
      4'b1001: e.res = (a < b) ? 32'd1 : 32'd0;
`endif
      default: e.il = 1'b1;
    endcase
    e.zf = (e.res == '0);
    return e;
  endfunction

  // Drive one operation; its result is checked one edge later against the queue head.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input string name);
    exp_t e;
    @(negedge clk);
    in_valid  = 1'b1;
    operation = op;
    in1       = a;
    in2       = b;
    sb_q.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      if ({out, zero, overflow, illegal, out_valid} !== {e.res, e.zf, e.of, e.il, 1'b1}) begin
        errors++;
        $display("FAIL %s: got out=%h zero=%b ovf=%b ill=%b vld=%b, expected out=%h zero=%b ovf=%b ill=%b vld=1",
                 name, out, zero, overflow, illegal, out_valid, e.res, e.zf, e.of, e.il);
      end
    end
  endtask

  task automatic idle_cycle;
    @(negedge clk);
    in_valid = 1'b0;
    in1      = $urandom;
    in2      = $urandom;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out, zero, overflow, illegal, out_valid} !== {32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got out=%h zero=%b ovf=%b ill=%b vld=%b, expected 00000000 1 0 0 0",
               out, zero, overflow, illegal, out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    idle_cycle();
    checks++;
    if ({out, zero, overflow, illegal, out_valid} !== {32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_release: got out=%h zero=%b ovf=%b ill=%b vld=%b, expected 00000000 1 0 0 0",
               out, zero, overflow, illegal, out_valid);
    end
  endtask

  task automatic test_logic;
    do_op(4'b0000, 32'hA5A5A5A5, 32'h5A5A5A5A, "and");
    do_op(4'b0001, 32'hA5A5A5A5, 32'h5A5A5A5A, "or");
    do_op(4'b1100, 32'hFFFF0000, 32'h0000FFFF, "nor_zero");
    do_op(4'b1100, 32'h0F0F0000, 32'h00000F0F, "nor");
  endtask

  task automatic test_arith;
    do_op(4'b0010, 32'd10, 32'd15, "add");
    do_op(4'b0110, 32'd10, 32'd15, "sub");
    do_op(4'b0111, 32'd10, 32'd15, "slt");
    do_op(4'b0010, 32'h7FFFFFFF, 32'h1, "add_ovf");
    do_op(4'b0010, 32'h0, 32'h0, "add_zero");
    do_op(4'b0110, 32'h80000000, 32'h1, "sub_ovf");
    do_op(4'b0110, 32'h5, 32'h5, "sub_zero");
    do_op(4'b0111, 32'h80000000, 32'h7FFFFFFF, "slt_ovf_true");
    do_op(4'b0111, 32'h7FFFFFFF, 32'h80000000, "slt_ovf_false");
    do_op(4'b0111, 32'hFFFFFFFF, 32'h00000001, "slt_neg");
  endtask

  task automatic test_ext_codes;
    do_op(4'b1111, 32'h1, 32'h1, "illegal_1111");
    do_op(4'b0011, 32'hF0F0F0F0, 32'h0FF00FF0, "xor_code");
    do_op(4'b0100, 32'h00000003, 32'd4, "sll_code");
    do_op(4'b0101, 32'h80000000, 32'd31, "srl_code");
    do_op(4'b1000, 32'h80000000, 32'd4, "sra_code");
    do_op(4'b1001, 32'h00000001, 32'hFFFFFFFF, "sltu_code");
    do_op(4'b1010, 32'h12345678, 32'h1, "illegal_1010");
  endtask

  task automatic test_hold;
    do_op(4'b0010, 32'd10, 32'd15, "hold_setup");
    idle_cycle();
    checks++;
    if ({out, zero, overflow, illegal, out_valid} !== {32'd25, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL hold: got out=%h zero=%b ovf=%b ill=%b vld=%b, expected 00000019 0 0 0 0",
               out, zero, overflow, illegal, out_valid);
    end
    idle_cycle();
    checks++;
    if ({out, out_valid} !== {32'd25, 1'b0}) begin
      errors++;
      $display("FAIL hold2: got out=%h vld=%b, expected 00000019 0", out, out_valid);
    end
  endtask

  task automatic test_reset_midstream;
    do_op(4'b0010, 32'h7FFFFFFF, 32'h1, "pre_reset");
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b1;
    operation = 4'b1111;
    in1       = 32'h1;
    in2       = 32'h2;
    @(posedge clk);
    #1;
    checks++;
    if ({out, zero, overflow, illegal, out_valid} !== {32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: got out=%h zero=%b ovf=%b ill=%b vld=%b, expected 00000000 1 0 0 0",
               out, zero, overflow, illegal, out_valid);
    end
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [3:0]   ops [11] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100,
                               4'b0011, 4'b0100, 4'b0101, 4'b1000, 4'b1001};
    logic [W-1:0] edges [5] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 4)] : W'($urandom);
      b = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 4)] : W'($urandom);
      do_op(ops[$urandom_range(0, 10)], a, b, "b2b");
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in1       = '0;
    in2       = '0;
    operation = 4'b0000;
    test_reset();
    test_logic();
    test_arith();
    test_ext_codes();
    test_hold();
    test_reset_midstream();
    test_back_to_back();
    idle_cycle();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
